// File: rtl/ibex_instr_responder.sv
// Instruction-side memory responder for an Ibex-style fetch port: fixed-latency, in-order responses.
// Optional error injection is enabled by defining IBEX_INSTR_RESP_ERR_INJ_EN.
module ibex_instr_responder #(
  parameter int unsigned Depth          = 1024,
  parameter int unsigned RespDelay      = 0,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     gnt_stall_i,
  input  logic                     load_we_i,
  input  logic [$clog2(Depth)-1:0] load_addr_i,
  input  logic [31:0]              load_wdata_i,
  input  logic                     err_inject_i,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = 3;

  logic [31:0]      mem_q [Depth];
  logic [RespDelay:0] vld_q;
  logic [31:0]      data_q [RespDelay+1];
  logic [RespDelay:0] err_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [29:0] word_idx_s;
  logic        oor_s;
  logic        gnt_s;
  logic        retire_s;
  logic        inj_err_s;
  logic        vld0_d;
  logic        err0_d;
  logic [31:0] data0_d;
  logic        unused_s;

  assign word_idx_s = instr_addr_i[31:2];
  assign oor_s      = (word_idx_s >= 30'(Depth));
  assign retire_s   = vld_q[RespDelay];
  assign gnt_s      = instr_req_i & ~gnt_stall_i & ~rst_i &
                      ((cnt_q < CW'(MaxOutstanding)) | retire_s);

`ifdef IBEX_INSTR_RESP_ERR_INJ_EN
  logic inj_q, inj_d;

  // A same-cycle pulse counts for the grant it coincides with.
  assign inj_err_s = inj_q | err_inject_i;
  assign unused_s  = ^instr_addr_i[1:0];

  // Injection latch: set by a pulse, consumed by the next grant.
  always_comb begin
    inj_d = inj_q;
    if (gnt_s) begin
      inj_d = 1'b0;
    end else begin
      inj_d = inj_err_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= inj_d;
    end
  end
`else
  assign inj_err_s = 1'b0;
  assign unused_s  = ^{instr_addr_i[1:0], err_inject_i};
`endif

  // Stage-0 capture: word read at the grant edge, before any same-edge load lands.
  always_comb begin
    vld0_d  = gnt_s;
    err0_d  = gnt_s & (oor_s | inj_err_s);
    data0_d = 32'h0000_0000;
    if (gnt_s && !(oor_s || inj_err_s)) begin
      data0_d = mem_q[instr_addr_i[AW+1:2]];
    end else begin
      data0_d = 32'h0000_0000;
    end
  end

  // Outstanding count: grant and retire in one cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({gnt_s, retire_s})
      2'b10: begin
        if (cnt_q < CW'(MaxOutstanding)) cnt_d = cnt_q + 3'd1;
        else                             cnt_d = cnt_q;
      end
      2'b01: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               cnt_d = cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Response pipeline and counter; idle stages carry zero data so outputs stay clean.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i <= int'(RespDelay); i++) begin
        data_q[i] <= 32'h0000_0000;
      end
    end else begin
      cnt_q     <= cnt_d;
      vld_q[0]  <= vld0_d;
      err_q[0]  <= err0_d;
      data_q[0] <= data0_d;
      for (int i = 1; i <= int'(RespDelay); i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Backing store; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  assign instr_gnt_o    = gnt_s;
  assign instr_rvalid_o = vld_q[RespDelay];
  assign instr_rdata_o  = data_q[RespDelay];
  assign instr_err_o    = err_q[RespDelay];
  assign busy_o         = (cnt_q != 3'd0);

endmodule

// File: tb/tb_ibex_instr_responder.sv
// Scoreboard bench for ibex_instr_responder: model predicts grants and queued responses.
module tb_ibex_instr_responder;

  localparam int DEPTH = 1024;
  localparam int RD    = 2;
  localparam int MO    = 2;

  logic        clk = 1'b0;
  logic        rst, req, gnt, rvalid, err, stall, load_we, inj, busy;
  logic [31:0] addr, rdata, load_wdata;
  logic [9:0]  load_addr;

  always #5 clk = ~clk;

  ibex_instr_responder #(.Depth(DEPTH), .RespDelay(RD), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
    .instr_err_o(err), .gnt_stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .err_inject_i(inj), .busy_o(busy)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          inj_m = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) chk_en <= 1'b1;
  end

  // Monitor and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin : monitor
    int   n_out;
    bit   due, exp_gnt, oor, e_err, inj_now;
    exp_t e;
    if (chk_en) begin
      n_out = sb.size();
      due   = (n_out > 0) && (sb[0].due == cyc);
      chk("rvalid", {31'b0, rvalid}, {31'b0, due});
      if (due) begin
        e = sb.pop_front();
        chk("rdata", rdata, e.data);
        chk("err", {31'b0, err}, {31'b0, e.err});
      end else begin
        chk("rdata_idle", rdata, 32'h0);
        chk("err_idle", {31'b0, err}, 32'h0);
      end
      chk("busy", {31'b0, busy}, {31'b0, (n_out != 0)});
      exp_gnt = req && !stall && !rst && ((n_out < MO) || due);
      chk("gnt", {31'b0, gnt}, {31'b0, exp_gnt});
`ifdef IBEX_INSTR_RESP_ERR_INJ_EN
      inj_now = inj_m || inj;
`else
      inj_now = 1'b0;
`endif
      if (exp_gnt) begin
        oor   = (addr[31:2] >= DEPTH);
        e_err = oor || inj_now;
        e.due  = cyc + RD + 1;
        e.err  = e_err;
        e.data = e_err ? 32'h0 : mem_m[addr[11:2]];
        sb.push_back(e);
        inj_m = 1'b0;
      end else begin
        inj_m = inj_now;
      end
      if (rst) begin
        sb.delete();
        inj_m = 1'b0;
      end
    end
    if (load_we) mem_m[load_addr] = load_wdata;
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(int w, logic [31:0] d);
    load_we = 1'b1; load_addr = 10'(w); load_wdata = d;
    step();
    load_we = 1'b0;
  endtask

  task automatic fetch(logic [31:0] a);
    req = 1'b1; addr = a;
    step();
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = 32'h0; stall = 1'b0; load_we = 1'b0;
    load_addr = 10'h0; load_wdata = 32'h0; inj = 1'b0;
    step(2);
    rst = 1'b0;
    for (int w = 0; w < DEPTH; w++) load(w, $urandom);

    // Single fetch of word 5
    load(5, 32'h0000_0013);
    fetch(32'h0000_0014);
    step(5);

    // Request held high against the outstanding limit
    req = 1'b1; addr = 32'h0000_0040;
    step(10);
    req = 1'b0;
    step(5);

    // Out-of-range address
    fetch(32'h0000_1000);
    step(5);

    // Load/read collision on word 3, then re-read
    load(3, 32'hAAAA_0000);
    load_we = 1'b1; load_addr = 10'd3; load_wdata = 32'h5555_FFFF;
    req = 1'b1; addr = 32'h0000_000C;
    step();
    load_we = 1'b0;
    step();
    req = 1'b0;
    step(5);

    // Reset one cycle after a grant
    fetch(32'h0000_0020);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(6);

    // Error injection pulse followed by two fetches of word 2
    inj = 1'b1;
    step();
    inj = 1'b0;
    fetch(32'h0000_0008);
    step(4);
    fetch(32'h0000_0008);
    step(5);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      load_we    = ($urandom_range(0, 3) == 0);
      load_addr  = 10'($urandom_range(0, DEPTH - 1));
      load_wdata = $urandom;
      inj        = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    req = 1'b0; stall = 1'b0; load_we = 1'b0; inj = 1'b0; rst = 1'b0;
    step(10);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
